secuenciador_init_rtc: RTL and testbench

- Parametrised successor to the fixed RTC initialisation FSM.
- Walks an external table of N_ENTRIES {address, data, write/address-only} entries.
- Drives each entry to the RTC bus controller and handshakes on siga for every transfer.
- Flags completion; can be re-armed by start. An optional timeout flags a stalled controller.

---
 rtl/secuenciador_init_rtc_if.sv | 30 +++
 rtl/secuenciador_init_rtc.sv | 137 +++++++++++++
 tb/tb_secuenciador_init_rtc.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secuenciador_init_rtc_if.sv
// Bus bundle between the RTC init sequencer (master), its entry table and
// the RTC bus controller (slave side).
interface secuenciador_init_rtc_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int IW = 4
);
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic          tbl_wr;
  logic [IW-1:0] idx;
  logic [AW-1:0] Direc;
  logic [DW-1:0] WR;
  logic          escriba;
  logic          req;
  logic          siga;
  logic          ocupado;
  logic          inicializado;
  logic          error;

  modport master (
    input  tbl_addr, tbl_data, tbl_wr, siga,
    output idx, Direc, WR, escriba, req, ocupado, inicializado, error
  );

  modport slave (
    output tbl_addr, tbl_data, tbl_wr, siga,
    input  idx, Direc, WR, escriba, req, ocupado, inicializado, error
  );
endinterface

// File: rtl/secuenciador_init_rtc.sv
// Table-driven RTC initialisation sequencer: walks N_ENTRIES table entries,
// handshaking each on siga. Define SECUENCIADOR_TIMEOUT_EN for the stall timeout.
module secuenciador_init_rtc #(
  parameter int N_ENTRIES = 16,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int HOLD      = 3,
  parameter int TOUT      = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  secuenciador_init_rtc_if.master bus
);
  localparam int IW = $clog2(N_ENTRIES);

  typedef enum logic [2:0] {
    IDLE, LOAD, DRIVE, WAIT_HI, WAIT_LO, NEXT, DONE, ERR
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] direc_q;
  logic [DW-1:0] wr_q;
  logic          escriba_q;
  logic          req_q;
  logic          ocupado_q;
  logic          inicializado_q;
  logic [3:0]    hold_q;

`ifdef SECUENCIADOR_TIMEOUT_EN
  localparam int CW = ($clog2(TOUT + 1) > 8) ? $clog2(TOUT + 1) : 8;
  logic [CW-1:0] wait_q;
  logic          error_q;
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      direc_q        <= '0;
      wr_q           <= '0;
      escriba_q      <= 1'b0;
      req_q          <= 1'b0;
      ocupado_q      <= 1'b0;
      inicializado_q <= 1'b0;
      hold_q         <= '0;
`ifdef SECUENCIADOR_TIMEOUT_EN
      wait_q         <= '0;
      error_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          // Only resting states accept start; pulses while busy fall through.
          if (start) begin
            state_q        <= LOAD;
            idx_q          <= '0;
            ocupado_q      <= 1'b1;
            inicializado_q <= 1'b0;
`ifdef SECUENCIADOR_TIMEOUT_EN
            error_q        <= 1'b0;
`endif
          end
        end
        LOAD: begin
          direc_q   <= bus.tbl_addr;
          wr_q      <= bus.tbl_wr ? bus.tbl_data : '0;
          escriba_q <= bus.tbl_wr;
          req_q     <= 1'b1;
          hold_q    <= '0;
          state_q   <= DRIVE;
        end
        DRIVE: begin
          if (hold_q == 4'(HOLD - 1)) begin
            req_q   <= 1'b0;
            state_q <= WAIT_HI;
`ifdef SECUENCIADOR_TIMEOUT_EN
            wait_q  <= '0;
`endif
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        WAIT_HI: begin
          if (bus.siga) begin
            state_q <= WAIT_LO;
`ifdef SECUENCIADOR_TIMEOUT_EN
            wait_q  <= '0;
          end else if (wait_q == CW'(TOUT - 1)) begin
            state_q   <= ERR;
            error_q   <= 1'b1;
            ocupado_q <= 1'b0;
          end else begin
            wait_q <= wait_q + 1'b1;
`endif
          end
        end
        WAIT_LO: begin
          if (!bus.siga) begin
            state_q <= NEXT;
`ifdef SECUENCIADOR_TIMEOUT_EN
          end else if (wait_q == CW'(TOUT - 1)) begin
            state_q   <= ERR;
            error_q   <= 1'b1;
            ocupado_q <= 1'b0;
          end else begin
            wait_q <= wait_q + 1'b1;
`endif
          end
        end
        NEXT: begin
          if (idx_q == IW'(N_ENTRIES - 1)) begin
            state_q        <= DONE;
            inicializado_q <= 1'b1;
            ocupado_q      <= 1'b0;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.idx          = idx_q;
  assign bus.Direc        = direc_q;
  assign bus.WR           = wr_q;
  assign bus.escriba      = escriba_q;
  assign bus.req          = req_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.inicializado = inicializado_q;
endmodule

// File: tb/tb_secuenciador_init_rtc.sv
// Directed bench for secuenciador_init_rtc with a 4-entry table and HOLD=3.
module tb_secuenciador_init_rtc;
  localparam int N    = 4;
  localparam int HOLD = 3;
  localparam int TOUT = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  secuenciador_init_rtc_if #(.AW(8), .DW(8), .IW(2)) bus ();

  secuenciador_init_rtc #(
    .N_ENTRIES(N), .AW(8), .DW(8), .HOLD(HOLD), .TOUT(TOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .bus  (bus)
  );

  logic [7:0] t_addr [4] = '{8'h02, 8'h10, 8'h00, 8'hF0};
  logic [7:0] t_data [4] = '{8'h10, 8'hD2, 8'h08, 8'h5A};
  logic       t_wr   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] x_wr   [4] = '{8'h10, 8'hD2, 8'h08, 8'h00};

  always_comb begin
    bus.tbl_addr = t_addr[bus.idx];
    bus.tbl_data = t_data[bus.idx];
    bus.tbl_wr   = t_wr[bus.idx];
  end

  initial bus.siga = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_entry(input int e, input bit give_siga, input bit poke_start);
    int n;
    int cnt;
    n = 0;
    while (bus.req !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (bus.req !== 1'b1) begin
      $display("FAIL req_rise entry %0d: req=%b required 1", e, bus.req);
      errors++;
      return;
    end
    checks++;
    if (bus.idx !== 2'(e)) begin
      $display("FAIL idx entry %0d: got %0d required %0d", e, bus.idx, e);
      errors++;
    end
    checks++;
    if (bus.Direc !== t_addr[e]) begin
      $display("FAIL Direc entry %0d: got %h required %h", e, bus.Direc, t_addr[e]);
      errors++;
    end
    checks++;
    if (bus.WR !== x_wr[e]) begin
      $display("FAIL WR entry %0d: got %h required %h", e, bus.WR, x_wr[e]);
      errors++;
    end
    checks++;
    if (bus.escriba !== t_wr[e]) begin
      $display("FAIL escriba entry %0d: got %b required %b", e, bus.escriba, t_wr[e]);
      errors++;
    end
    cnt = 0;
    while (bus.req === 1'b1 && cnt < 10) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != HOLD) begin
      $display("FAIL req_width entry %0d: got %0d cycles required %0d", e, cnt, HOLD);
      errors++;
    end
    $display("entry %0d: Direc=%h WR=%h escriba=%b req_cycles=%0d", e, bus.Direc, bus.WR,
             bus.escriba, cnt);
    if (!give_siga) return;
    tick();
    tick();
    bus.siga = 1'b1;
    if (poke_start) start = 1'b1;
    repeat (5) tick();
    start    = 1'b0;
    bus.siga = 1'b0;
  endtask

  task automatic finish_done();
    tick();
    checks++;
    if (bus.inicializado !== 1'b0) begin
      $display("FAIL init_early: inicializado=%b required 0", bus.inicializado);
      errors++;
    end
    tick();
    checks++;
    if (bus.inicializado !== 1'b1 || bus.ocupado !== 1'b0 || bus.error !== 1'b0) begin
      $display("FAIL done_flags: init=%b ocupado=%b error=%b required 1/0/0",
               bus.inicializado, bus.ocupado, bus.error);
      errors++;
    end
    checks++;
    if (bus.Direc !== 8'hF0 || bus.WR !== 8'h00 || bus.escriba !== 1'b0 || bus.idx !== 2'd3) begin
      $display("FAIL done_hold: Direc=%h WR=%h escriba=%b idx=%0d required F0/00/0/3",
               bus.Direc, bus.WR, bus.escriba, bus.idx);
      errors++;
    end
    $display("sequence done: inicializado=%b", bus.inicializado);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.idx, bus.Direc, bus.WR, bus.escriba, bus.req, bus.ocupado,
         bus.inicializado, bus.error} !== 24'h0) begin
      $display("FAIL reset_values: idx=%0d Direc=%h WR=%h esc=%b req=%b ocu=%b init=%b err=%b required all 0",
               bus.idx, bus.Direc, bus.WR, bus.escriba, bus.req, bus.ocupado,
               bus.inicializado, bus.error);
      errors++;
    end
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.ocupado !== 1'b0 || bus.req !== 1'b0) begin
      $display("FAIL idle_hold: ocupado=%b req=%b required 0/0", bus.ocupado, bus.req);
      errors++;
    end
  endtask

  task automatic test_start_latency();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (bus.ocupado !== 1'b1 || bus.req !== 1'b0 || bus.idx !== 2'd0) begin
      $display("FAIL latency_load: ocupado=%b req=%b idx=%0d required 1/0/0",
               bus.ocupado, bus.req, bus.idx);
      errors++;
    end
    tick();
    checks++;
    if (bus.req !== 1'b1) begin
      $display("FAIL latency_req: req=%b required 1", bus.req);
      errors++;
    end
  endtask

  task automatic test_basic_sequence();
    for (int e = 0; e < N; e++) do_entry(e, 1'b1, 1'b0);
    finish_done();
  endtask

  task automatic test_rearm();
    pulse_start();
    checks++;
    if (bus.inicializado !== 1'b0 || bus.ocupado !== 1'b1) begin
      $display("FAIL rearm: inicializado=%b ocupado=%b required 0/1", bus.inicializado, bus.ocupado);
      errors++;
    end
    for (int e = 0; e < N; e++) do_entry(e, 1'b1, 1'b1);
    finish_done();
  endtask

  task automatic test_missing_siga();
    pulse_start();
    do_entry(0, 1'b0, 1'b0);
`ifdef SECUENCIADOR_TIMEOUT_EN
    repeat (19) tick();
    checks++;
    if (bus.error !== 1'b0) begin
      $display("FAIL hi_timeout_early: error=%b required 0", bus.error);
      errors++;
    end
    tick();
    checks++;
    if (bus.error !== 1'b1 || bus.idx !== 2'd0 || bus.ocupado !== 1'b0) begin
      $display("FAIL hi_timeout: error=%b idx=%0d ocupado=%b required 1/0/0",
               bus.error, bus.idx, bus.ocupado);
      errors++;
    end
`else
    repeat (40) tick();
    checks++;
    if (bus.req !== 1'b0 || bus.idx !== 2'd0 || bus.inicializado !== 1'b0 ||
        bus.ocupado !== 1'b1 || bus.error !== 1'b0) begin
      $display("FAIL stuck_wait_hi: req=%b idx=%0d init=%b ocupado=%b error=%b required 0/0/0/1/0",
               bus.req, bus.idx, bus.inicializado, bus.ocupado, bus.error);
      errors++;
    end
`endif
    $display("missing siga: idx=%0d ocupado=%b error=%b", bus.idx, bus.ocupado, bus.error);
  endtask

  task automatic test_reset_mid_op();
    int n;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    do_entry(0, 1'b1, 1'b0);
    n = 0;
    while (bus.req !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0 || bus.Direc !== 8'h00 || bus.WR !== 8'h00 ||
        bus.idx !== 2'd0 || bus.ocupado !== 1'b0) begin
      $display("FAIL async_reset: req=%b Direc=%h WR=%h idx=%0d ocupado=%b required all 0",
               bus.req, bus.Direc, bus.WR, bus.idx, bus.ocupado);
      errors++;
    end
    start = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    start = 1'b0;
    $display("reset mid-op: restarting");
    for (int e = 0; e < N; e++) do_entry(e, 1'b1, 1'b0);
    finish_done();
  endtask

`ifdef SECUENCIADOR_TIMEOUT_EN
  task automatic test_timeout();
    pulse_start();
    do_entry(0, 1'b1, 1'b0);
    do_entry(1, 1'b1, 1'b0);
    do_entry(2, 1'b0, 1'b0);
    tick();
    tick();
    bus.siga = 1'b1;
    repeat (20) tick();
    checks++;
    if (bus.error !== 1'b0) begin
      $display("FAIL lo_timeout_early: error=%b required 0", bus.error);
      errors++;
    end
    tick();
    checks++;
    if (bus.error !== 1'b1 || bus.idx !== 2'd2 || bus.req !== 1'b0 || bus.ocupado !== 1'b0) begin
      $display("FAIL lo_timeout: error=%b idx=%0d req=%b ocupado=%b required 1/2/0/0",
               bus.error, bus.idx, bus.req, bus.ocupado);
      errors++;
    end
    bus.siga = 1'b0;
    pulse_start();
    checks++;
    if (bus.error !== 1'b0 || bus.idx !== 2'd0 || bus.ocupado !== 1'b1) begin
      $display("FAIL err_restart: error=%b idx=%0d ocupado=%b required 0/0/1",
               bus.error, bus.idx, bus.ocupado);
      errors++;
    end
    for (int e = 0; e < N; e++) do_entry(e, 1'b1, 1'b0);
    finish_done();
  endtask
`endif

  initial begin
    test_reset();
    test_start_latency();
    test_basic_sequence();
    test_rearm();
    test_missing_siga();
    test_reset_mid_op();
`ifdef SECUENCIADOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
